// File: rtl/tag_pair_generator_pkg.sv
// Shared types and helpers for the synthetic start/click tag source.
package tag_pair_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam int WORD_WIDTH_DEF = 4;
  localparam int PAIRS_PER_BEAT = WORD_WIDTH_DEF / 2;
  localparam int KEEP_MAX       = 64;

  // Each pair occupies two lanes, so n pairs light the low 2n keep bits.
  function automatic logic [KEEP_MAX-1:0] pair_keep(input int n);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (i < 2 * n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tag_beat_builder.sv
// Combinational lane packer: npairs start/click pairs from time t, unused lanes zeroed.
module tag_beat_builder
  import tag_pair_generator_pkg::*;
#(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int NP_WIDTH      = 2
) (
  input  logic [TIME_WIDTH-1:0]               t,
  input  logic [TIME_WIDTH-1:0]               period,
  input  logic [TIME_WIDTH-1:0]               delay,
  input  logic [CHANNEL_WIDTH-1:0]            start_channel,
  input  logic [CHANNEL_WIDTH-1:0]            click_channel,
  input  logic [NP_WIDTH-1:0]                 npairs,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]    tagtime,
  output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] channel,
  output logic [WORD_WIDTH-1:0]               keep
);

  localparam int P = WORD_WIDTH / 2;

  logic [KEEP_MAX-1:0]   keep_full;
  logic [TIME_WIDTH-1:0] base;

  always_comb begin
    tagtime   = '0;
    channel   = '0;
    base      = t;
    keep_full = pair_keep(int'(npairs));
    keep      = keep_full[WORD_WIDTH-1:0];
    for (int k = 0; k < P; k++) begin
      if (k < int'(npairs)) begin
        tagtime[(2*k)*TIME_WIDTH +: TIME_WIDTH]         = base;
        tagtime[(2*k+1)*TIME_WIDTH +: TIME_WIDTH]       = base + delay;
        channel[(2*k)*CHANNEL_WIDTH +: CHANNEL_WIDTH]   = start_channel;
        channel[(2*k+1)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = click_channel;
      end
      // Running sum instead of k*period: wraps modulo 2^TIME_WIDTH the same way.
      base = base + period;
    end
  end

endmodule

// File: rtl/tag_pair_generator.sv
// Synthetic tag stream source emitting start/click pairs, one registered beat per cycle.
// Output register reloads on !tvalid || tready; all stream outputs hold while stalled.
module tag_pair_generator
  import tag_pair_generator_pkg::*;
#(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic                               stop_i,
  input  logic [TIME_WIDTH-1:0]              period_i,
  input  logic [TIME_WIDTH-1:0]              delay_i,
  input  logic [TIME_WIDTH-1:0]              first_time_i,
  input  logic [CHANNEL_WIDTH-1:0]           start_channel_i,
  input  logic [CHANNEL_WIDTH-1:0]           click_channel_i,
  input  logic [CNT_WIDTH-1:0]               num_events_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [CNT_WIDTH-1:0]               events_sent_o,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [WORD_WIDTH-1:0]              m_axis_tkeep,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]   m_axis_tagtime,
  output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] m_axis_channel,
  output logic [TIME_WIDTH-1:0]              m_axis_lowest_time
);

  localparam int P   = WORD_WIDTH / 2;
  localparam int NPW = $clog2(P + 1);

  state_t state, state_nxt;

  logic [TIME_WIDTH-1:0]    t_q, period_q, delay_q;
  logic [CHANNEL_WIDTH-1:0] sch_q, cch_q;
  logic [CNT_WIDTH-1:0]     remaining_q;
  logic                     unbounded_q;
  logic [NPW-1:0]           beat_pairs_q, npairs;
  logic                     load, accept, final_beat, cfg_ok;
  logic [CNT_WIDTH:0]       sent_sum;

  logic [WORD_WIDTH*TIME_WIDTH-1:0]    b_tagtime;
  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] b_channel;
  logic [WORD_WIDTH-1:0]               b_keep;

  tag_beat_builder #(
    .WORD_WIDTH   (WORD_WIDTH),
    .TIME_WIDTH   (TIME_WIDTH),
    .CHANNEL_WIDTH(CHANNEL_WIDTH),
    .NP_WIDTH     (NPW)
  ) u_builder (
    .t            (t_q),
    .period       (period_q),
    .delay        (delay_q),
    .start_channel(sch_q),
    .click_channel(cch_q),
    .npairs       (npairs),
    .tagtime      (b_tagtime),
    .channel      (b_channel),
    .keep         (b_keep)
  );

  assign busy_o = (state != IDLE);

  always_comb begin
    npairs     = NPW'(P);
    final_beat = 1'b0;
    if (!unbounded_q && remaining_q < CNT_WIDTH'(P)) npairs = NPW'(remaining_q);
    if (!unbounded_q && remaining_q <= CNT_WIDTH'(P)) final_beat = 1'b1;
    accept   = m_axis_tvalid && m_axis_tready;
    load     = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
    cfg_ok   = (period_i != '0) && (delay_i < period_i);
    sent_sum = {1'b0, events_sent_o} + (CNT_WIDTH+1)'(beat_pairs_q);
    state_nxt = state;
    unique case (state)
      IDLE: if (start_i && cfg_ok) state_nxt = RUN;
      // A stop while stalled makes the held beat the last one.
      RUN:  if ((load && final_beat) || stop_i) state_nxt = LAST;
      LAST: if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      t_q                <= '0;
      period_q           <= '0;
      delay_q            <= '0;
      sch_q              <= '0;
      cch_q              <= '0;
      remaining_q        <= '0;
      unbounded_q        <= 1'b0;
      beat_pairs_q       <= '0;
      done_o             <= 1'b0;
      err_o              <= 1'b0;
      events_sent_o      <= '0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tkeep       <= '0;
      m_axis_tagtime     <= '0;
      m_axis_channel     <= '0;
      m_axis_lowest_time <= '0;
    end else begin
      state  <= state_nxt;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (state == IDLE && start_i) begin
        if (cfg_ok) begin
          t_q           <= first_time_i;
          period_q      <= period_i;
          delay_q       <= delay_i;
          sch_q         <= start_channel_i;
          cch_q         <= click_channel_i;
          remaining_q   <= num_events_i;
          unbounded_q   <= (num_events_i == '0);
          events_sent_o <= '0;
        end else begin
          err_o <= 1'b1;
        end
      end
      if (accept) begin
        events_sent_o <= sent_sum[CNT_WIDTH] ? '1 : sent_sum[CNT_WIDTH-1:0];
      end
      if (load) begin
        m_axis_tvalid      <= 1'b1;
        m_axis_tkeep       <= b_keep;
        m_axis_tagtime     <= b_tagtime;
        m_axis_channel     <= b_channel;
        m_axis_lowest_time <= b_tagtime[TIME_WIDTH-1:0];
        beat_pairs_q       <= npairs;
        t_q                <= t_q + TIME_WIDTH'(npairs) * period_q;
        if (!unbounded_q) remaining_q <= remaining_q - CNT_WIDTH'(npairs);
      end
      if (state == LAST && accept) begin
        m_axis_tvalid <= 1'b0;
        done_o        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_pair_generator.sv
// Bench for tag_pair_generator: config table plus random configs against a tag-list model.
module tb_tag_pair_generator;
  import tag_pair_generator_pkg::*;

  localparam int WW = 4, TW = 64, CW = 6, NW = 32, P = WW / 2;

  logic clk = 1'b0;
  logic rst, start_i, stop_i;
  logic [TW-1:0] period_i, delay_i, first_time_i;
  logic [CW-1:0] start_channel_i, click_channel_i;
  logic [NW-1:0] num_events_i;
  logic busy_o, done_o, err_o;
  logic [NW-1:0] events_sent_o;
  logic m_axis_tvalid, m_axis_tready;
  logic [WW-1:0] m_axis_tkeep;
  logic [WW*TW-1:0] m_axis_tagtime;
  logic [WW*CW-1:0] m_axis_channel;
  logic [TW-1:0] m_axis_lowest_time;

  always #5 clk = ~clk;

  tag_pair_generator #(.WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .period_i(period_i), .delay_i(delay_i), .first_time_i(first_time_i),
    .start_channel_i(start_channel_i), .click_channel_i(click_channel_i),
    .num_events_i(num_events_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .events_sent_o(events_sent_o), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tagtime(m_axis_tagtime), .m_axis_channel(m_axis_channel),
    .m_axis_lowest_time(m_axis_lowest_time)
  );

  typedef struct {
    logic [TW-1:0] ft, per, dly;
    logic [CW-1:0] sch, cch;
    logic [NW-1:0] n;
    int            rdy_pct;
    int            stop_at;
    bit            exp_err;
  } vec_t;

  vec_t vecs[$];
  int total = 0, bad = 0;
  logic [WW*TW-1:0] first_beat_time, last_beat_time;
  logic [WW-1:0]    last_beat_keep;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [TW-1:0]    pidx, s;
    logic [WW*TW-1:0] et, snap_t;
    logic [WW*CW-1:0] ec, snap_c;
    logic [WW-1:0]    ek, snap_k;
    logic [TW-1:0]    snap_l;
    int cyc, np, beats, errs, last_acc, done_cyc, stop_cyc, after_stop;
    bit stalled, rdy, unb;
    @(negedge clk);
    first_time_i = v.ft; period_i = v.per; delay_i = v.dly;
    start_channel_i = v.sch; click_channel_i = v.cch; num_events_i = v.n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (v.exp_err) begin
      check("err_pulse", err_o, 1);
      check("err_busy", busy_o, 0);
      @(negedge clk);
      check("err_clear", err_o, 0);
      check("err_idle_busy", busy_o, 0);
      check("err_tvalid", m_axis_tvalid, 0);
      return;
    end
    check("start_busy", busy_o, 1);
    check("start_events_clr", events_sent_o, 0);
    unb = (v.n == 0);
    pidx = '0; beats = 0; errs = 0; last_acc = -1; done_cyc = -1;
    stop_cyc = -1; after_stop = 0; stalled = 0;
    snap_t = '0; snap_c = '0; snap_k = '0; snap_l = '0;
    for (cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      if (err_o) errs++;
      if (done_o) done_cyc = cyc;
      if (stalled) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_keep", m_axis_tkeep, snap_k);
        check("hold_time", m_axis_tagtime, snap_t);
        check("hold_chan", m_axis_channel, snap_c);
        check("hold_lowest", m_axis_lowest_time, snap_l);
      end
      if (done_cyc >= 0) break;
      rdy = ($urandom_range(99) < v.rdy_pct);
      m_axis_tready = rdy;
      stop_i = (cyc == v.stop_at);
      // A start while busy, with invalid config, must be ignored silently.
      start_i = (cyc == 3);
      if (cyc == 3) period_i = '0;
      if (m_axis_tvalid && rdy) begin
        if (unb) np = P;
        else if (pidx >= TW'(v.n)) np = 0;
        else np = (TW'(v.n) - pidx < TW'(P)) ? int'(TW'(v.n) - pidx) : P;
        et = '0; ec = '0; ek = '0;
        for (int k = 0; k < np; k++) begin
          s = v.ft + (pidx + TW'(k)) * v.per;
          et[(2*k)*TW +: TW] = s;
          et[(2*k+1)*TW +: TW] = s + v.dly;
          ec[(2*k)*CW +: CW] = v.sch;
          ec[(2*k+1)*CW +: CW] = v.cch;
          ek[2*k] = 1'b1;
          ek[2*k+1] = 1'b1;
        end
        check("beat_keep", m_axis_tkeep, ek);
        check("beat_time", m_axis_tagtime, et);
        check("beat_chan", m_axis_channel, ec);
        check("beat_lowest", m_axis_lowest_time, et[TW-1:0]);
        if (beats == 0) first_beat_time = m_axis_tagtime;
        last_beat_time = m_axis_tagtime;
        last_beat_keep = m_axis_tkeep;
        beats++;
        last_acc = cyc;
        pidx = pidx + TW'(np);
        if (stop_cyc >= 0) after_stop++;
      end
      if (stop_i) stop_cyc = cyc;
      stalled = m_axis_tvalid && !rdy;
      snap_t = m_axis_tagtime; snap_c = m_axis_channel;
      snap_k = m_axis_tkeep; snap_l = m_axis_lowest_time;
      @(negedge clk);
      start_i = 1'b0;
      stop_i = 1'b0;
    end
    m_axis_tready = 1'b0;
    check("done_seen", done_cyc >= 0, 1);
    check("done_timing", done_cyc, last_acc + 1);
    check("done_busy", busy_o, 0);
    check("done_tvalid", m_axis_tvalid, 0);
    check("no_err_while_busy", errs, 0);
    if (unb) begin
      check("events_unbounded", events_sent_o, beats * P);
      check("beats_after_stop", after_stop, 1);
    end else begin
      check("events_bounded", events_sent_o, v.n);
      check("pairs_total", pidx, TW'(v.n));
    end
    @(negedge clk);
    check("done_single_pulse", done_o, 0);
  endtask

  function automatic vec_t mk(input logic [TW-1:0] ft, per, dly, input int sch, cch,
                              input logic [NW-1:0] n, input int rdy, stop, input bit e);
    vec_t v;
    v.ft = ft; v.per = per; v.dly = dly; v.sch = CW'(sch); v.cch = CW'(cch);
    v.n = n; v.rdy_pct = rdy; v.stop_at = stop; v.exp_err = e;
    return v;
  endfunction

  initial begin
    int unsigned p32;
    int dones;
    logic [TW-1:0] big;
    rst = 1'b1; start_i = 0; stop_i = 0; period_i = 0; delay_i = 0; first_time_i = 0;
    start_channel_i = 0; click_channel_i = 0; num_events_i = 0; m_axis_tready = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_keep", m_axis_tkeep, 0);
    check("rst_events", events_sent_o, 0);
    check("rst_time", m_axis_tagtime, 0);
    check("rst_chan", m_axis_channel, 0);
    check("rst_lowest", m_axis_lowest_time, 0);
    rst = 1'b0;

    big = 64'hFFFF_FFFF_FFFF_FDA8; // 2^64 - 600
    vecs.push_back(mk(64'd1000, 64'd500, 64'd120, 1, 2, 2, 100, -1, 0));
    vecs.push_back(mk(64'd1000, 64'd500, 64'd120, 1, 2, 3, 100, -1, 0));
    vecs.push_back(mk(64'd5000, 64'd77, 64'd76, 3, 60, 11, 50, -1, 0));
    vecs.push_back(mk(big, 64'd500, 64'd10, 5, 6, 4, 100, -1, 0));
    vecs.push_back(mk(64'd1000, 64'd500, 64'd500, 1, 2, 2, 100, -1, 1));
    vecs.push_back(mk(64'd1000, 64'd0, 64'd0, 1, 2, 2, 100, -1, 1));
    vecs.push_back(mk(64'd200, 64'd40, 64'd3, 7, 8, 0, 50, 10, 0));
    vecs.push_back(mk(64'd0, 64'd1, 64'd0, 63, 0, 7, 70, -1, 0));
    for (int i = 0; i < 6; i++) begin
      p32 = $urandom_range(1000, 1);
      vecs.push_back(mk({$urandom, $urandom}, TW'(p32), TW'($urandom_range(p32 - 1, 0)),
                        int'($urandom_range(63)), int'($urandom_range(63)),
                        NW'($urandom_range(9, 1)), int'($urandom_range(100, 30)), -1, 0));
    end
    vecs.push_back(mk(64'd9, 64'd300, 64'd299, 2, 4, 0, 50, int'($urandom_range(20, 5)), 0));

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (i == 0) check("single_beat_times", first_beat_time,
                        {64'd1620, 64'd1500, 64'd1120, 64'd1000});
      if (i == 1) begin
        check("tail_keep", last_beat_keep, 4'b0011);
        check("tail_times", last_beat_time, {64'd0, 64'd0, 64'd2120, 64'd2000});
      end
      if (i == 3) check("wrap_lane2", first_beat_time[2*TW +: TW], 64'hFFFF_FFFF_FFFF_FF9C);
    end

    // Reset while a beat is stalled on the output.
    @(negedge clk);
    first_time_i = 64'd50; period_i = 64'd100; delay_i = 64'd10; num_events_i = 0;
    start_i = 1'b1; m_axis_tready = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    m_axis_tready = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_tvalid", m_axis_tvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tvalid", m_axis_tvalid, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_events", events_sent_o, 0);
    check("rst_mid_keep", m_axis_tkeep, 0);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o || m_axis_tvalid) dones++;
    end
    check("rst_mid_no_done", dones, 0);

    // stop_i in IDLE must not start anything.
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_pair_generator.md
Name: tag_pair_generator

Overview:
- Synthetic tag source: the transmitting end of the tag AXI-stream that the measurement modules consume.
- Emits start/click tag pairs with a programmable period and delay, packed into stream beats.
- Used for on-FPGA self-test of the histogram and counter paths, and as a bench stimulus source.
- Sits in front of axis_broadcast, muxed in place of the link-decoded tag stream.

Parameters:
WORD_WIDTH, 4, tag lanes per beat; must be even and >=2
TIME_WIDTH, 64, tag timestamp width (ps)
CHANNEL_WIDTH, 6, channel number width
CNT_WIDTH, 32, event counter width

Ports:
clk  in  1  stream clock
rst  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse: latch config, begin generation
stop_i  in  1  one-cycle pulse: finish the current beat, then stop
period_i  in  TIME_WIDTH  spacing between consecutive start tags
delay_i  in  TIME_WIDTH  click-tag offset after its start tag
first_time_i  in  TIME_WIDTH  timestamp of the first start tag
start_channel_i  in  CHANNEL_WIDTH  channel of start tags
click_channel_i  in  CHANNEL_WIDTH  channel of click tags
num_events_i  in  CNT_WIDTH  pairs to send; 0 = unbounded
busy_o  out  1  generator active
done_o  out  1  one-cycle pulse after the final beat is accepted
err_o  out  1  one-cycle pulse: start rejected because config is invalid
events_sent_o  out  CNT_WIDTH  pairs accepted downstream since the last start
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tkeep  out  WORD_WIDTH  lane valid mask; contiguous from lane 0
m_axis_tagtime  out  WORD_WIDTH*TIME_WIDTH  lane timestamps; lane 0 in the LSBs
m_axis_channel  out  WORD_WIDTH*CHANNEL_WIDTH  lane channels
m_axis_lowest_time  out  TIME_WIDTH  timestamp of lane 0

Behaviour:
- Reset values:
  - outputs busy_o, done_o, err_o, m_axis_tvalid, m_axis_tkeep, events_sent_o, tagtime, channel and lowest_time are all 0.
  - FSM is in IDLE.
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - start_i with period_i==0 or delay_i>=period_i -> err_o pulse next cycle; stay in IDLE.
  - Otherwise, start_i:
    - latches all config inputs.
    - sets t=first_time_i and clears events_sent_o.
    - goes to RUN with busy_o=1.
    - first beat has tvalid high at cycle n+1.
  - stop_i in IDLE is ignored.
- RUN:
  - The output register loads a new beat when !tvalid || tready, so throughput is one beat per cycle.
  - Each beat carries P=WORD_WIDTH/2 pairs, or fewer if fewer remain.
  - Pair k is placed in lanes 2k and 2k+1:
    - lane 2k: start tag at time t+k*period.
    - lane 2k+1: click tag at t+k*period+delay.
  - After loading a beat, t advances by (pairs in the beat)*period.
  - The loaded beat containing the final pair -> LAST.
  - stop_i -> LAST without loading a further beat. If stop_i coincides with a load, that loaded beat is the final one.
- LAST:
  - Holds the final beat until tready.
  - On acceptance: done_o pulses, busy_o clears, tvalid drops, state -> IDLE.
- Handshake:
  - While tvalid=1 and tready=0, every m_axis_* output is held stable.
  - tvalid never drops without acceptance, except on rst.
- Arithmetic:
  - All time sums are modulo 2^TIME_WIDTH; wrap-around is permitted and not flagged.
  - Within a beat, tags are in non-decreasing time order, since delay<period.
- Counting:
  - events_sent_o increments by the pair count of each accepted beat.
  - It saturates at all-ones.
  - With num_events_i=0, generation runs until stop_i.
- start_i while busy is ignored, with no error.
- rst mid-operation: tvalid=0 on the next cycle; any partial beat is discarded and no done_o is issued.
- Unused lanes: tkeep bit 0; tagtime and channel for those lanes are 0.

Decomposition:
- tag_pair_generator_pkg holds:
  - state_t enum (IDLE, RUN, LAST).
  - localparam PAIRS_PER_BEAT = WORD_WIDTH/2.
  - function pair_keep(n) returning the tkeep mask for n pairs.
- One sub-module, tag_beat_builder: purely combinational.
  - Inputs: t, period, delay, channels, pair count.
  - Output: lane times, channels and keep.
  - The FSM and output register stay in the top module.

Test Plan:
- Single beat: WORD_WIDTH=4, first_time=1000, period=500, delay=120, ch 1/2, num_events=2, tready=1 -> one beat.
  - times 1000/1120/1500/1620, channels 1,2,1,2, keep 1111.
  - done_o on the cycle after acceptance; events_sent_o=2.
- Partial tail: num_events=3 -> beat 1 keep 1111, beat 2 keep 0011 with times 2000/2120; done_o once; events_sent_o=3.
- Backpressure: tready toggles randomly at 50% -> no tvalid drop, data stable while stalled, lanes contiguous across beats, every lane time increasing.
- Stop/unbounded: num_events=0, stop_i at cycle 10 -> the beat in flight completes, then done_o; events_sent_o equals 2x the accepted beats.
- Config and wrap errors:
  - delay=500 with period=500 -> err_o, busy_o stays 0.
  - first_time=2^64-600, period=500 -> second tag time wraps to 2^64-100, third to 400 mod 2^64.
- Reset mid-run: rst while tvalid=1 and tready=0 -> tvalid=0 on the next cycle, no done_o, events_sent_o=0.
